// File: rtl/gamepad_reader.sv
// rtl/gamepad_reader.sv - NES-style gamepad poller with debounce, direction cancel and press pulses
module gamepad_reader #(
  parameter int CLK_HALF       = 6,
  parameter int POLL_PERIOD    = 416000,
  parameter int DEBOUNCE_POLLS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pad_data,
  output logic pad_latch,
  output logic pad_clk,
  output logic A,
  output logic B,
  output logic select,
  output logic start,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic A_press,
  output logic B_press,
  output logic poll_done
);

  localparam int CNT_MAX = (POLL_PERIOD > 2 * CLK_HALF) ? POLL_PERIOD : 2 * CLK_HALF;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] IDLE_LAST  = CW'(POLL_PERIOD - 1);
  localparam logic [CW-1:0] PHASE_LAST = CW'(2 * CLK_HALF - 1);
  localparam logic [CW-1:0] HALF       = CW'(CLK_HALF);
  localparam logic [1:0]    DEB_LAST   = 2'(DEBOUNCE_POLLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SHIFT, S_UPDATE} state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      raw;
  logic [7:0]      stable;
  logic [7:0]      stable_n;
  logic [7:0][1:0] deb_cnt;
  logic [7:0][1:0] deb_n;
  logic [7:0]      btn;
  logic [7:0]      btn_n;
  logic [1:0]      sync;
  logic            sample_edge;

  // Bit i of the pad is sampled on the last cycle of the latch pulse or of each clock low phase
  assign sample_edge = ((state == S_LATCH) || (state == S_SHIFT)) && (cnt == PHASE_LAST);

  // Two-flop synchroniser; idles at the released level
  always_ff @(posedge clk) begin
    if (!reset) sync <= 2'b11;
    else        sync <= {sync[0], pad_data};
  end

  // State register; reset aborts any poll in progress
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state: idle wait, latch pulse, seven shift bits, single update cycle
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (cnt == IDLE_LAST) state_n = S_LATCH;
      S_LATCH:  if (cnt == PHASE_LAST) state_n = S_SHIFT;
      S_SHIFT:  if ((cnt == PHASE_LAST) && (bit_idx == 3'd7)) state_n = S_UPDATE;
      S_UPDATE: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Phase counter restarts on every state change and on every shift-bit boundary; bits captured inverted
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      raw     <= '0;
    end else begin
      if ((state != state_n) || ((state == S_SHIFT) && (cnt == PHASE_LAST))) cnt <= '0;
      else                                                                   cnt <= cnt + 1'b1;
      if (sample_edge) begin
        raw[bit_idx] <= ~sync[1];
        bit_idx      <= bit_idx + 3'd1;
      end
    end
  end

  // Per-button debounce and opposing-direction cancellation, evaluated for the update cycle
  always_comb begin
    stable_n = stable;
    deb_n    = deb_cnt;
    for (int i = 0; i < 8; i++) begin
      if (raw[i] == stable[i]) begin
        deb_n[i] = 2'd0;
      end else if (deb_cnt[i] == DEB_LAST) begin
        stable_n[i] = raw[i];
        deb_n[i]    = 2'd0;
      end else begin
        deb_n[i] = deb_cnt[i] + 2'd1;
      end
    end
    btn_n    = stable_n;
    btn_n[4] = stable_n[4] & ~stable_n[5];
    btn_n[5] = stable_n[5] & ~stable_n[4];
    btn_n[6] = stable_n[6] & ~stable_n[7];
    btn_n[7] = stable_n[7] & ~stable_n[6];
  end

  // Button state commits only at the end of the update cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      stable  <= '0;
      deb_cnt <= '0;
      btn     <= '0;
    end else if (state == S_UPDATE) begin
      stable  <= stable_n;
      deb_cnt <= deb_n;
      btn     <= btn_n;
    end
  end

  // Outputs decoded from state; press pulses flag a 0->1 about to commit this update
  always_comb begin
    pad_latch = (state == S_LATCH);
    pad_clk   = (state == S_SHIFT) && (cnt < HALF);
    poll_done = (state == S_UPDATE);
    A_press   = poll_done & btn_n[0] & ~btn[0];
    B_press   = poll_done & btn_n[1] & ~btn[1];
  end

  assign A      = btn[0];
  assign B      = btn[1];
  assign select = btn[2];
  assign start  = btn[3];
  assign up     = btn[4];
  assign down   = btn[5];
  assign left   = btn[6];
  assign right  = btn[7];

endmodule

// File: tb/tb_gamepad_reader.sv
// tb/tb_gamepad_reader.sv - self-checking bench for gamepad_reader with pad model and poll-level reference
module tb_gamepad_reader;

  localparam int H   = 4;
  localparam int P   = 16;
  localparam int DEB = 2;
  localparam int T   = P + 16 * H + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pad_data;
  logic pad_latch, pad_clk, A, B, select, start, up, down, left, right, A_press, B_press, poll_done;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] img = 8'h00;
  logic       present = 1'b1;
  logic [7:0] lat_img = 8'h00;
  int         idx = 0;

  always #5 clk = ~clk;

  gamepad_reader #(.CLK_HALF(H), .POLL_PERIOD(P), .DEBOUNCE_POLLS(DEB)) dut (
    .clk(clk), .reset(reset), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk),
    .A(A), .B(B), .select(select), .start(start),
    .up(up), .down(down), .left(left), .right(right),
    .A_press(A_press), .B_press(B_press), .poll_done(poll_done)
  );

  // pad: parallel load while latch high, advance one bit per rising pad_clk, active-low output
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) begin
      lat_img = img;
      idx = 0;
    end else begin
      idx = idx + 1;
    end
  end
  assign pad_data = (!present || idx > 7) ? 1'b1 : ~lat_img[idx];

  // reference model: poll schedule from cycle arithmetic, debounce as consecutive-disagree streaks
  logic       rst_at_edge;
  always @(posedge clk) rst_at_edge <= reset;

  int         k = 0, cyc = 0, last_done = -1, done_gap = 0, apress_cnt = 0, a_high_cnt = 0;
  bit         mvalid = 0;
  logic [7:0] m_stable = 8'h00, m_out = 8'h00, nout, raw_m;
  int         m_streak [8];
  int         ph;
  logic       e_latch, e_clk, e_done, e_ap, e_bp;
  logic [12:0] exp_v, act_v;

  always @(negedge clk) begin
    cyc++;
    if (rst_at_edge === 1'b0) begin
      mvalid = 1; k = 0; m_stable = 8'h00; m_out = 8'h00; last_done = -1;
      for (int i = 0; i < 8; i++) m_streak[i] = 0;
    end else if (mvalid) begin
      k++;
    end
    if (mvalid) begin
      ph = k % T;
      e_latch = (ph >= P) && (ph < P + 2 * H);
      e_clk   = (ph >= P + 2 * H) && (ph < P + 16 * H) && (((ph - P - 2 * H) % (2 * H)) < H);
      e_done  = (ph == T - 1);
      e_ap = 1'b0; e_bp = 1'b0; nout = m_out;
      if (e_done) begin
        raw_m = present ? img : 8'h00;
        for (int i = 0; i < 8; i++) begin
          if (raw_m[i] == m_stable[i]) m_streak[i] = 0;
          else begin
            m_streak[i]++;
            if (m_streak[i] >= DEB) begin m_stable[i] = raw_m[i]; m_streak[i] = 0; end
          end
        end
        nout = m_stable;
        nout[4] = m_stable[4] & ~m_stable[5];
        nout[5] = m_stable[5] & ~m_stable[4];
        nout[6] = m_stable[6] & ~m_stable[7];
        nout[7] = m_stable[7] & ~m_stable[6];
        e_ap = nout[0] & ~m_out[0];
        e_bp = nout[1] & ~m_out[1];
      end
      exp_v = {e_latch, e_clk, e_done, e_ap, e_bp, m_out};
      act_v = {pad_latch, pad_clk, poll_done, A_press, B_press, right, left, down, up, start, select, B, A};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++;
        if (n_fail < 30) $display("FAIL model cyc=%0d ph=%0d {latch,clk,done,ap,bp,btn} got %b expected %b", cyc, ph, act_v, exp_v);
      end
      m_out = nout;
    end
    if (poll_done === 1'b1) begin
      if (last_done >= 0) done_gap = cyc - last_done;
      last_done = cyc;
    end
    if (A_press === 1'b1) apress_cnt++;
    if (A === 1'b1) a_high_cnt++;
  end

  function automatic logic [7:0] btns();
    return {right, left, down, up, start, select, B, A};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic poll_once();
    int w;
    w = 0;
    while (poll_done !== 1'b1 && w < 300) begin @(negedge clk); w++; end
    if (poll_done !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL poll_timeout: got no poll_done expected one within 300 cycles");
    end
    @(negedge clk);
  endtask

  // called just after the final reset edge; ends on the negedge of the first UPDATE cycle
  task automatic measure_startup(input string tag);
    int c, w, hi, rises;
    logic prev;
    c = -1;
    do begin @(negedge clk); c++; end while (pad_latch !== 1'b1 && c < 100);
    check({tag, "_latch_delay"}, c, 16);
    w = 0;
    while (pad_latch === 1'b1 && w < 50) begin w++; @(negedge clk); end
    check({tag, "_latch_width"}, w, 8);
    hi = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 7 * 2 * H; i++) begin
      if (pad_clk === 1'b1) hi++;
      if (pad_clk === 1'b1 && prev !== 1'b1) rises++;
      prev = pad_clk;
      @(negedge clk);
    end
    check({tag, "_clk_high_cycles"}, hi, 28);
    check({tag, "_clk_pulses"}, rises, 7);
  endtask

  int ap0, ah0, nrep;

  initial begin
    // 1: reset and startup timing
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("reset_outputs", {pad_latch, pad_clk, poll_done, A_press, B_press, btns()}, 0);
    measure_startup("s1");
    poll_once();

    // 2: A held
    img = 8'h01;
    ap0 = apress_cnt;
    poll_once();
    check("A_after_poll1", A, 0);
    poll_once();
    check("A_after_poll2", A, 1);
    check("A_press_count_poll2", apress_cnt - ap0, 1);
    ap0 = apress_cnt;
    poll_once(); poll_once();
    check("A_press_held", apress_cnt - ap0, 0);
    img = 8'h00;
    poll_once(); poll_once();
    check("A_released", A, 0);

    // 3: single-poll glitch
    ap0 = apress_cnt; ah0 = a_high_cnt;
    img = 8'h01;
    poll_once();
    img = 8'h00;
    poll_once(); poll_once(); poll_once();
    check("glitch_A_high", a_high_cnt - ah0, 0);
    check("glitch_A_press", apress_cnt - ap0, 0);

    // 4: opposing directions
    img = 8'h30; poll_once(); poll_once();
    check("up_down_cancel", {up, down}, 2'b00);
    img = 8'h10; poll_once(); poll_once();
    check("up_after_release", {up, down}, 2'b10);
    img = 8'hC0; poll_once(); poll_once();
    check("left_right_cancel", {left, right, up}, 3'b000);
    img = 8'h40; poll_once(); poll_once();
    check("left_after_release", {left, right}, 2'b10);
    img = 8'h00; poll_once(); poll_once();

    // 5: pad removed
    img = 8'h09; poll_once(); poll_once();
    check("A_start_held", btns(), 8'h09);
    present = 1'b0; img = 8'hFF;
    poll_once();
    check("no_pad_poll1", btns(), 8'h09);
    poll_once();
    check("no_pad_poll2", btns(), 8'h00);
    poll_once(); poll_once();
    check("no_pad_stays0", btns(), 8'h00);
    check("poll_period", done_gap, T);

    // 6: reset mid-shift with B held
    present = 1'b1; img = 8'h02;
    poll_once(); poll_once();
    check("B_held", B, 1);
    nrep = 0;
    while (pad_latch !== 1'b1 && nrep < 200) begin @(negedge clk); nrep++; end
    repeat (25) @(negedge clk);
    @(posedge clk);
    #1;
    check("pre_reset_pad_clk", pad_clk, 1);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    check("abort_pads", {pad_latch, pad_clk}, 2'b00);
    check("abort_outputs", btns(), 8'h00);
    measure_startup("s6");
    poll_once();
    check("B_after_restart_poll1", B, 0);
    poll_once();
    check("B_after_restart_poll2", B, 1);

    // randomized images and pad presence against the model
    for (int it = 0; it < 30; it++) begin
      img = 8'($urandom);
      present = ($urandom_range(0, 7) != 0);
      nrep = $urandom_range(1, 3);
      for (int j = 0; j < nrep; j++) poll_once();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got no completion expected finish before 2 ms");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
